// File: rtl/imuldiv_div_requester_if.sv
// Val/rdy channels between the pipeline, the iterative divider and writeback,
// as seen by the divide requester.
interface imuldiv_div_requester_if;
  localparam int unsigned DataW = 32;
  localparam int unsigned TagW  = 5;
  localparam int unsigned LatW  = 16;

  logic              op_val;
  logic              op_rdy;
  logic [1:0]        op_fn;
  logic [DataW-1:0]  op_a;
  logic [DataW-1:0]  op_b;
  logic [TagW-1:0]   op_tag;

  logic              divreq_msg_fn;
  logic [DataW-1:0]  divreq_msg_a;
  logic [DataW-1:0]  divreq_msg_b;
  logic              divreq_val;
  logic              divreq_rdy;

  logic [2*DataW-1:0] divresp_msg_result;
  logic              divresp_val;
  logic              divresp_rdy;

  logic              wb_val;
  logic              wb_rdy;
  logic [DataW-1:0]  wb_data;
  logic [TagW-1:0]   wb_tag;

  logic              busy;
  logic [LatW-1:0]   last_latency;

  modport master (
    input  op_val, op_fn, op_a, op_b, op_tag,
    output op_rdy,
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    input  divreq_rdy,
    input  divresp_msg_result, divresp_val,
    output divresp_rdy,
    output wb_val, wb_data, wb_tag,
    input  wb_rdy,
    output busy, last_latency
  );

  modport slave (
    output op_val, op_fn, op_a, op_b, op_tag,
    input  op_rdy,
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    output divreq_rdy,
    output divresp_msg_result, divresp_val,
    input  divresp_rdy,
    input  wb_val, wb_data, wb_tag,
    output wb_rdy,
    input  busy, last_latency
  );
endinterface

// File: rtl/imuldiv_div_requester.sv
// Issues one div/divu/rem/remu to the iterative divider, selects quotient or
// remainder, and returns it on writeback; divide-by-zero bypasses the divider.
module imuldiv_div_requester (
  input  logic                     clk,
  input  logic                     reset,
  imuldiv_div_requester_if.master  bus
);
  localparam int unsigned DataW = 32;
  localparam int unsigned TagW  = 5;
  localparam int unsigned CntW  = 16;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t            state;
  state_t            state_next;
  logic [1:0]        fn;
  logic [DataW-1:0]  a;
  logic [DataW-1:0]  b;
  logic [DataW-1:0]  result;
  logic [TagW-1:0]   tag;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_inc;
  logic [CntW-1:0]   lat;
  logic              op_go;
  logic              resp_go;

  // Saturating cycle count shared by the counter and the latency capture.
  assign count_inc = (count == '1) ? count : count + CntW'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Outputs decode the current state and are forced low while reset is high.
  always_comb begin
    state_next         = state;
    op_go              = 1'b0;
    resp_go            = 1'b0;
    bus.op_rdy         = 1'b0;
    bus.divreq_val     = 1'b0;
    bus.divreq_msg_fn  = 1'b0;
    bus.divreq_msg_a   = '0;
    bus.divreq_msg_b   = '0;
    bus.divresp_rdy    = 1'b0;
    bus.wb_val         = 1'b0;
    bus.wb_data        = '0;
    bus.wb_tag         = '0;
    bus.busy           = 1'b0;
    bus.last_latency   = '0;
    if (!reset) begin
      bus.last_latency = lat;
      case (state)
        IDLE: begin
          bus.op_rdy = 1'b1;
          op_go      = bus.op_val;
          if (op_go) state_next = (bus.op_b == '0) ? WB : REQ;
        end
        REQ: begin
          bus.busy          = 1'b1;
          bus.divreq_val    = 1'b1;
          bus.divreq_msg_fn = fn[0];
          bus.divreq_msg_a  = a;
          bus.divreq_msg_b  = b;
          if (bus.divreq_rdy) state_next = WAIT;
        end
        WAIT: begin
          bus.busy        = 1'b1;
          bus.divresp_rdy = 1'b1;
          resp_go         = bus.divresp_val;
          if (resp_go) state_next = WB;
        end
        WB: begin
          bus.busy    = 1'b1;
          bus.wb_val  = 1'b1;
          bus.wb_data = result;
          bus.wb_tag  = tag;
          if (bus.wb_rdy) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Operand capture, zero-divisor shortcut, response select and latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn     <= '0;
      a      <= '0;
      b      <= '0;
      tag    <= '0;
      result <= '0;
      count  <= '0;
      lat    <= '0;
    end else begin
      if (op_go) begin
        fn    <= bus.op_fn;
        a     <= bus.op_a;
        b     <= bus.op_b;
        tag   <= bus.op_tag;
        count <= '0;
        if (bus.op_b == '0) begin
          result <= bus.op_fn[1] ? bus.op_a : '1;
          lat    <= '0;
        end
      end else if (state == REQ || state == WAIT) begin
        count <= count_inc;
      end
      if (resp_go) begin
        result <= fn[1] ? bus.divresp_msg_result[2*DataW-1:DataW]
                        : bus.divresp_msg_result[DataW-1:0];
        lat    <= count_inc;
      end
    end
  end
endmodule

// File: tb/tb_imuldiv_div_requester.sv
// Scoreboard bench for imuldiv_div_requester: directed cases plus random ops,
// with a behavioural divider and writeback sink driving the far side.
module tb_imuldiv_div_requester;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imuldiv_div_requester_if ifc();
  imuldiv_div_requester dut (.clk(clk), .reset(reset), .bus(ifc));

  typedef struct { logic [31:0] data; logic [4:0] tag; logic [15:0] lat; } exp_t;
  typedef struct { logic fn; logic [31:0] a; logic [31:0] b; } req_t;

  exp_t sb_q[$];
  req_t rq_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_stall = 0, resp_lat = 0, wb_stall = 0;
  bit spur = 1'b0;
  int last_wb_edge = -10;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference divider arithmetic: {remainder, quotient}.
  function automatic logic [63:0] div_model(input logic uns, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    int unsigned ux, uy;
    if (uns) begin
      ux = x; uy = y;
      return {32'(ux % uy), 32'(ux / uy)};
    end
    sx = x; sy = y;
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] fn, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] r;
    if (y == 32'd0) return fn[1] ? x : 32'hFFFF_FFFF;
    r = div_model(fn[0], x, y);
    return fn[1] ? r[63:32] : r[31:0];
  endfunction

  // Behavioural divider: stalls the request, then answers after resp_lat cycles.
  int dv_state = 0, dv_cnt = 0;
  logic dv_fn;
  logic [31:0] dv_a, dv_b;
  always @(negedge clk) begin
    if (reset) begin
      dv_state = 0; dv_cnt = 0;
      ifc.divreq_rdy = 1'b0; ifc.divresp_val = 1'b0; ifc.divresp_msg_result = '0;
    end else if (spur) begin
      ifc.divreq_rdy = 1'b0; ifc.divresp_val = 1'b1;
      ifc.divresp_msg_result = 64'hDEAD_BEEF_0BAD_F00D;
      dv_state = 0; dv_cnt = 0;
    end else begin
      case (dv_state)
        0: begin
          ifc.divresp_val = 1'b0;
          if (ifc.divreq_val) begin
            if (rq_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL divreq_unexpected: divreq_val=1 required 0 (cycle %0d)", cyc);
            end else begin
              chk("divreq_msg_fn", 64'(ifc.divreq_msg_fn), 64'(rq_q[0].fn));
              chk("divreq_msg_a", 64'(ifc.divreq_msg_a), 64'(rq_q[0].a));
              chk("divreq_msg_b", 64'(ifc.divreq_msg_b), 64'(rq_q[0].b));
            end
            if (dv_cnt >= req_stall) begin
              ifc.divreq_rdy = 1'b1;
              dv_fn = ifc.divreq_msg_fn; dv_a = ifc.divreq_msg_a; dv_b = ifc.divreq_msg_b;
              if (rq_q.size() != 0) void'(rq_q.pop_front());
              dv_state = 1; dv_cnt = 0;
            end else begin
              ifc.divreq_rdy = 1'b0;
              dv_cnt++;
            end
          end
        end
        1: begin
          ifc.divreq_rdy = 1'b0;
          if (dv_cnt == 0) chk("no_double_issue", 64'(ifc.divreq_val), 64'd0);
          if (dv_cnt >= resp_lat) begin
            ifc.divresp_val = 1'b1;
            ifc.divresp_msg_result = div_model(dv_fn, dv_a, dv_b);
            dv_state = 2;
          end else begin
            dv_cnt++;
          end
        end
        default: begin
          ifc.divresp_val = 1'b0;
          dv_state = 0; dv_cnt = 0;
        end
      endcase
    end
  end

  // Writeback sink and scoreboard monitor.
  int wcnt = 0;
  bit prev_hold = 1'b0;
  logic [31:0] prev_data;
  logic [4:0] prev_tag;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      ifc.wb_rdy = 1'b0; wcnt = 0; prev_hold = 1'b0;
    end else if (ifc.wb_val) begin
      if (prev_hold) begin
        chk("wb_data_stable", 64'(ifc.wb_data), 64'(prev_data));
        chk("wb_tag_stable", 64'(ifc.wb_tag), 64'(prev_tag));
      end
      if (wcnt >= wb_stall) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: wb_val=1 tag=%0d required no writeback", ifc.wb_tag);
        end else begin
          e = sb_q.pop_front();
          chk("wb_data", 64'(ifc.wb_data), 64'(e.data));
          chk("wb_tag", 64'(ifc.wb_tag), 64'(e.tag));
          chk("last_latency", 64'(ifc.last_latency), 64'(e.lat));
        end
        ifc.wb_rdy = 1'b1;
        last_wb_edge = cyc + 1;
        wcnt = 0; prev_hold = 1'b0;
      end else begin
        ifc.wb_rdy = 1'b0;
        prev_data = ifc.wb_data; prev_tag = ifc.wb_tag; prev_hold = 1'b1;
        wcnt++;
      end
    end else begin
      ifc.wb_rdy = 1'b0; wcnt = 0; prev_hold = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset && ifc.busy) chk("op_rdy_while_busy", 64'(ifc.op_rdy), 64'd0);
  end

  // Offer one op; expectations are queued on the accepting edge.
  task automatic issue(input logic [1:0] fn, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] tag, input int s, input int l, input int w,
                       input bit hold, input bit b2b);
    int t;
    exp_t e;
    req_t r;
    t = 0;
    @(negedge clk);
    ifc.op_val = 1'b1; ifc.op_fn = fn; ifc.op_a = x; ifc.op_b = y; ifc.op_tag = tag;
    while (!ifc.op_rdy && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++; errors++;
      $display("FAIL op_accept_timeout: op_rdy=0 for %0d cycles, required 1 (tag %0d)", t, tag);
      ifc.op_val = 1'b0;
      return;
    end
    req_stall = s; resp_lat = l; wb_stall = w;
    if (b2b) chk("b2b_accept_edge", 64'(cyc + 1), 64'(last_wb_edge + 1));
    e.data = ref_result(fn, x, y);
    e.tag = tag;
    e.lat = (y == 32'd0) ? 16'd0 : 16'(s + l + 2);
    sb_q.push_back(e);
    if (y != 32'd0) begin
      r.fn = fn[0]; r.a = x; r.b = y;
      rq_q.push_back(r);
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      ifc.op_val = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_op_rdy"}, 64'(ifc.op_rdy), 64'd0);
    chk({tagname, "_divreq_val"}, 64'(ifc.divreq_val), 64'd0);
    chk({tagname, "_divresp_rdy"}, 64'(ifc.divresp_rdy), 64'd0);
    chk({tagname, "_wb_val"}, 64'(ifc.wb_val), 64'd0);
    chk({tagname, "_busy"}, 64'(ifc.busy), 64'd0);
    chk({tagname, "_msg"}, {31'd0, ifc.divreq_msg_fn, ifc.divreq_msg_a}, 64'd0);
    chk({tagname, "_wb_data"}, {27'd0, ifc.wb_tag, ifc.wb_data}, 64'd0);
    chk({tagname, "_last_latency"}, 64'(ifc.last_latency), 64'd0);
  endtask

  initial begin
    logic [1:0] rfn;
    logic [31:0] ra, rb;
    bit held;
    int t;

    ifc.op_val = 1'b0; ifc.op_fn = '0; ifc.op_a = '0; ifc.op_b = '0; ifc.op_tag = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("op_rdy_after_reset", 64'(ifc.op_rdy), 64'd1);

    issue(2'b01, 32'd100, 32'd7, 5'd3, 0, 3, 0, 1'b0, 1'b0);
    issue(2'b10, 32'hFFFF_FFEF, 32'd5, 5'd9, 1, 0, 0, 1'b0, 1'b0);

    // Zero divisor: writeback one cycle after acceptance, divider untouched.
    issue(2'b00, 32'd42, 32'd0, 5'd4, 0, 0, 0, 1'b0, 1'b0);
    chk("zero_div_wb_cycle1", 64'(ifc.wb_val), 64'd1);
    issue(2'b11, 32'd42, 32'd0, 5'd5, 0, 0, 0, 1'b0, 1'b0);
    chk("zero_rem_wb_cycle1", 64'(ifc.wb_val), 64'd1);

    // Backpressure on both the divider request and writeback.
    issue(2'b01, 32'hDEAD_0001, 32'd13, 5'd6, 5, 2, 4, 1'b0, 1'b0);

    // Reset while waiting on the divider, then a stray response.
    issue(2'b01, 32'd1000, 32'd3, 5'd7, 0, 30, 0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("wait_divresp_rdy", 64'(ifc.divresp_rdy), 64'd1);
    reset = 1'b1;
    sb_q.delete(); rq_q.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_op_rdy", 64'(ifc.op_rdy), 64'd1);
      chk("post_reset_busy", 64'(ifc.busy), 64'd0);
      chk("post_reset_wb_val", 64'(ifc.wb_val), 64'd0);
      chk("post_reset_last_latency", 64'(ifc.last_latency), 64'd0);
    end
    spur = 1'b0;
    issue(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd8, 0, 1, 0, 1'b0, 1'b0);

    // Back-to-back with op_val held high.
    issue(2'b00, 32'd77, 32'd0, 5'd10, 0, 0, 0, 1'b1, 1'b0);
    issue(2'b01, 32'd500, 32'd9, 5'd11, 0, 0, 0, 1'b1, 1'b1);
    issue(2'b11, 32'd500, 32'd9, 5'd12, 1, 1, 1, 1'b1, 1'b1);
    issue(2'b10, 32'd9, 32'd0, 5'd13, 0, 0, 2, 1'b0, 1'b1);

    held = 1'b0;
    for (int i = 0; i < 40; i++) begin
      rfn = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 300)) - 32'd150;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 20)) - 32'd10;
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && $urandom_range(0, 1) == 1) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd2;
      issue(rfn, ra, rb, 5'(i), $urandom_range(0, 3), $urandom_range(0, 4),
            $urandom_range(0, 2), (i != 39) && ($urandom_range(0, 1) == 1), held);
      held = ifc.op_val;
    end

    t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d writebacks outstanding, required 0", sb_q.size());
    end
    repeat (3) @(negedge clk);
    chk("final_idle_busy", 64'(ifc.busy), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imuldiv_div_requester.md
# imuldiv_div_requester

Request-side controller for the iterative divider. It sits between the PARC X stage and the divider's `divreq`/`divresp` val/rdy interface. It accepts one div/divu/rem/remu operation from the pipeline and issues the matching divider request. It then consumes the 64-bit response, selects the quotient or remainder, and returns the 32-bit result with its destination tag on a writeback val/rdy channel. It also short-circuits divide-by-zero and records per-operation latency for performance counters.

## Interface
- No parameters. Widths are fixed at 32-bit operands and a 5-bit tag.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- op_val  in  1  pipeline operation valid
- op_rdy  out  1  requester can accept an operation
- op_fn  in  2  00 div, 01 divu, 10 rem, 11 remu
- op_a  in  32  dividend
- op_b  in  32  divisor
- op_tag  in  5  destination register
- divreq_msg_fn  out  1  0 = signed, 1 = unsigned
- divreq_msg_a  out  32  dividend to the divider
- divreq_msg_b  out  32  divisor to the divider
- divreq_val  out  1  divider request valid
- divreq_rdy  in  1  divider request ready
- divresp_msg_result  in  64  {remainder[63:32], quotient[31:0]}
- divresp_val  in  1  divider response valid
- divresp_rdy  out  1  requester ready for the response
- wb_val  out  1  writeback valid
- wb_rdy  in  1  writeback ready
- wb_data  out  32  selected result
- wb_tag  out  5  tag of the completed operation
- busy  out  1  high in any state other than IDLE
- last_latency  out  16  cycles from REQ entry to response capture for the last completed divide; saturates at 16'hFFFF

## Operation
- The FSM has four states: IDLE, REQ, WAIT, WB.
- Registers: fn (2 bits), a, b, tag, result (32 bits), count (16 bits), last_latency.
- IDLE:
  - op_rdy=1; all other outputs low.
  - On op_val && op_rdy, latch op_fn, op_a, op_b and op_tag.
  - If op_b==0, load result directly and go to WB. Div/divu give 32'hFFFFFFFF; rem/remu give op_a. Set last_latency=0.
  - Otherwise clear count and go to REQ.
- REQ:
  - divreq_val=1.
  - divreq_msg_fn=fn[0]. divreq_msg_a and divreq_msg_b come from the a and b registers.
  - The request fields are stable while divreq_val is high.
  - On divreq_rdy, go to WAIT.
- WAIT:
  - divresp_rdy=1.
  - On divresp_val, result gets divresp_msg_result[63:32] if fn[1]=1, otherwise [31:0].
  - On the same edge, last_latency gets count+1 (saturating), and the FSM goes to WB.
- count increments every cycle in REQ and WAIT, saturating at 16'hFFFF.
- WB:
  - wb_val=1; wb_data=result; wb_tag=tag.
  - Data and tag are stable until the handshake.
  - On wb_rdy, go to IDLE.
- op_rdy is asserted only in IDLE, so there is no op acceptance in the same cycle as wb completion.
- There is no special case for signed overflow (0x80000000 / -1); the divider's answer is forwarded unchanged.
- A divresp_val seen outside WAIT is ignored, because divresp_rdy=0.

## Timing
- Reset:
  - While reset is high: state=IDLE, and op_rdy, divreq_val, divresp_rdy, wb_val and busy are all 0.
  - divreq_msg_* outputs are 0. wb_data, wb_tag and last_latency are 0.
  - op_rdy=1 on the first cycle after reset deasserts.
- Reset mid-operation abandons the operation with no writeback. The divider shares the same reset, so no stale response survives.
- Nonzero divisor, ready environment:
  - Op accepted at edge 0.
  - divreq_val high during cycle 1.
  - divresp_rdy high from cycle 2.
  - With divider response latency L, wb_val rises the cycle after divresp capture.
  - Minimum is 4 cycles per op with a zero-latency divider.
- Zero divisor: op accepted at edge 0; wb_val high in cycle 1.
- Each handshake completes on the edge where val && rdy.
- Backpressure on divreq_rdy or wb_rdy holds the current state indefinitely, with all outputs stable.

## Test plan
- Reset, then divu with a=100, b=7; divider responds after 3 cycles; wb_rdy=1. Required:
  - wb_data=14, correct tag.
  - divreq_msg_fn=1.
  - last_latency equals the observed REQ-to-capture cycles.
- rem with a=-17 (0xFFFFFFEF), b=5; divider responds {0xFFFFFFFE, 0xFFFFFFFD}. Required:
  - divreq_msg_fn=0.
  - wb_data=0xFFFFFFFE.
- div with b=0, a=42. Required:
  - No divreq_val ever asserted.
  - wb_val high in cycle 1 after acceptance, wb_data=0xFFFFFFFF.
  - last_latency=0.
- Repeat with remu, b=0, a=42. Required: wb_data=42.
- Backpressure: divreq_rdy=0 for 5 cycles, then wb_rdy=0 for 4 cycles. Required:
  - divreq_msg_* and wb_data/wb_tag stable throughout.
  - op_rdy=0 until the WB handshake completes.
  - No double issue.
- Reset asserted in WAIT, with a spurious divresp_val afterwards. Required:
  - No wb_val.
  - op_rdy=1 the cycle after reset deasserts.
  - busy=0.
  - The spurious response is not captured.
- Back-to-back ops with op_val held high. Required:
  - The second op is accepted only in the cycle after the WB handshake.
  - Tags appear in order.
